uart_slot_arbiter: RTL and testbench
====================================

UART_SLOT_ARBITER -- requirements
Module: uart_slot_arbiter

Interface
REQ-001 The block SHALL have parameter DVSR_INIT, default 11'd650, the baud divisor written to the UART slot after reset.
REQ-002 The block SHALL have the following ports: clk input 1, rising-edge clock; reset input 1, asynchronous, active-high.
REQ-003 cfg_load input 1: pulse requesting a divisor reprogram; cfg_dvsr input 11: new divisor, sampled with cfg_load.
REQ-004 req0_valid input 1, req0_data input 8, req0_ready output 1: TX requester 0.
REQ-005 req1_valid input 1, req1_data input 8, req1_ready output 1: TX requester 1.
REQ-006 rx_valid output 1, rx_data output 8, rx_ready input 1: received-byte stream.
REQ-007 uart_cs, uart_read, uart_write output 1 each; uart_addr output 5; uart_wr_data output 32: UART slot master side.
REQ-008 uart_rd_data input 32: UART slot status, [9]=tx_full, [8]=rx_empty, [7:0]=rx byte; valid every cycle with no read latency.
REQ-009 busy output 1: high whenever state is not IDLE or a cfg reprogram is pending.

Function
REQ-010 The FSM SHALL have states INIT, IDLE, CFG, TX, POP, one slot transaction per non-IDLE state, each lasting exactly 1 cycle, then returning to IDLE.
REQ-011 Slot writes SHALL use uart_cs=1 and uart_write=1, with uart_addr[1:0] set as follows: INIT/CFG=01 with uart_wr_data={21'b0, divisor}; TX=10 with uart_wr_data={24'b0, byte}; POP=11 with uart_wr_data=0; uart_addr[4:2]=0 always.
REQ-012 In IDLE the block SHALL drive uart_cs=1, uart_read=1, uart_write=0, uart_addr=0, and SHALL evaluate the status bits from uart_rd_data.
REQ-013 In every other state uart_read SHALL be 0; no write SHALL be issued from IDLE itself, so a minimum of one IDLE cycle separates writes, letting FIFO flags settle.
REQ-014 IDLE priority SHALL be: pending cfg -> CFG; else (rx_empty==0 and rx holding register empty) -> POP; else (tx_full==0 and any req valid) -> TX; else stay in IDLE.
REQ-015 cfg_load SHALL set cfg_pending and capture cfg_dvsr in any state; a second cfg_load before service SHALL overwrite the captured value; CFG SHALL clear cfg_pending.
REQ-016 On IDLE->POP the block SHALL capture uart_rd_data[7:0] into rx_hold and set rx_full; rx_valid=rx_full and rx_data=rx_hold.
REQ-017 rx_valid&&rx_ready SHALL clear rx_full on the next edge; a capture and a clear in the same cycle are impossible by REQ-014.
REQ-018 Round-robin: register last_grant (1 bit); if both requesters are valid, grant !last_grant; if one is valid, grant it; update last_grant on TX.
REQ-019 The grant and byte SHALL be latched on IDLE->TX; in the TX cycle, req<g>_ready=1 for the granted requester only, and the byte is consumed.
REQ-020 req_ready SHALL be 0 in all other cycles; a requester dropping valid between grant and TX SHALL still have the latched byte transmitted.
REQ-021 While tx_full==1 no TX SHALL be issued, and requesters SHALL stall with ready=0.
REQ-022 Throughput SHALL be at most one slot write per 2 cycles.

Reset
REQ-023 Asserting reset at any time SHALL force state=INIT, cfg_pending=0, rx_full=0, rx_hold=0, last_grant=1, latched grant/byte=0, req0_ready=req1_ready=rx_valid=0, and uart_write=uart_read=0.
REQ-024 During reset, uart_cs=0, uart_addr=0, uart_wr_data=0, rx_data=0, and busy=1.
REQ-025 On the first clock after reset deassertion, INIT SHALL write DVSR_INIT (addr 01) for one cycle, then enter IDLE.
REQ-026 A transaction interrupted by reset SHALL be dropped; an accepted-but-unsent byte SHALL not be retried.

Verification
REQ-027 Reset release -> cycle 1: uart_write=1, addr=01, wr_data=650; cycle 2: IDLE with uart_read=1.
REQ-028 Both reqs valid continuously (0x41, 0x42), tx_full=0 -> TX bytes in order 0x41,0x42,0x41,... every 2 cycles, ready alternating req0/req1.
REQ-029 tx_full=1 with req0 valid -> no write at addr 10 and req0_ready=0; tx_full drops -> TX within 2 cycles.
REQ-030 rx_empty=0 with byte 0x5A and rx_ready=0 -> one POP (addr 11), rx_valid=1 with rx_data=0x5A; no further POP until rx_ready=1 clears rx_full.
REQ-031 cfg_load with 0x100, then cfg_load with 0x1A0 during TX -> single CFG write of 0x1A0, served before a simultaneously pending POP/TX.
REQ-032 Reset pulsed during TX cycle -> next cycles show INIT write of DVSR_INIT, rx_valid=0, and no replay of the byte.

Source files
------------

// File: rtl/uart_slot_arbiter.sv
// Shares one memory-mapped UART slot between divisor reprogramming, two
// round-robin TX requesters and a one-byte RX holding register.
module uart_slot_arbiter #(
    parameter logic [10:0] DVSR_INIT = 11'd650
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cfg_load,
    input  logic [10:0] cfg_dvsr,
    input  logic        req0_valid,
    input  logic [7:0]  req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [7:0]  req1_data,
    output logic        req1_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        uart_cs,
    output logic        uart_read,
    output logic        uart_write,
    output logic [4:0]  uart_addr,
    output logic [31:0] uart_wr_data,
    input  logic [31:0] uart_rd_data,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_CFG,
        ST_TX,
        ST_POP
    } state_t;

    localparam logic [4:0] ADDR_STATUS = 5'b00000;
    localparam logic [4:0] ADDR_DVSR   = 5'b00001;
    localparam logic [4:0] ADDR_TX     = 5'b00010;
    localparam logic [4:0] ADDR_POP    = 5'b00011;

    state_t      r_state;
    state_t      w_next_state;
    logic        r_cfg_pending;
    logic [10:0] r_cfg_dvsr;
    logic        r_rx_full;
    logic [7:0]  r_rx_hold;
    logic        r_last_grant;
    logic        r_grant;
    logic [7:0]  r_tx_byte;

    logic w_tx_full;
    logic w_rx_empty;
    logic w_any_req;
    logic w_grant;
    logic w_unused;

    assign w_tx_full  = uart_rd_data[9];
    assign w_rx_empty = uart_rd_data[8];
    assign w_any_req  = req0_valid | req1_valid;
    assign w_unused   = ^uart_rd_data[31:10];

    // Alternate only under contention; a lone requester always wins.
    assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
        end else begin
            // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
            r_state <= w_next_state;
        end
    end

    always_comb begin
        // NOTE: every always_comb target gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (r_cfg_pending) begin
                    w_next_state = ST_CFG;
                end else if (!w_rx_empty && !r_rx_full) begin
                    w_next_state = ST_POP;
                end else if (!w_tx_full && w_any_req) begin
                    w_next_state = ST_TX;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_cs      = 1'b0;
        uart_read    = 1'b0;
        uart_write   = 1'b0;
        uart_addr    = ADDR_STATUS;
        uart_wr_data = 32'd0;
        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        if (!reset) begin
            case (r_state)
                ST_IDLE: begin
                    uart_cs   = 1'b1;
                    uart_read = 1'b1;
                end
                ST_INIT: begin
                    uart_cs      = 1'b1;
                    uart_write   = 1'b1;
                    uart_addr    = ADDR_DVSR;
                    uart_wr_data = {21'd0, DVSR_INIT};
                end
                ST_CFG: begin
                    uart_cs      = 1'b1;
                    uart_write   = 1'b1;
                    uart_addr    = ADDR_DVSR;
                    uart_wr_data = {21'd0, r_cfg_dvsr};
                end
                ST_TX: begin
                    uart_cs      = 1'b1;
                    uart_write   = 1'b1;
                    uart_addr    = ADDR_TX;
                    uart_wr_data = {24'd0, r_tx_byte};
                    req0_ready   = ~r_grant;
                    req1_ready   = r_grant;
                end
                ST_POP: begin
                    uart_cs    = 1'b1;
                    uart_write = 1'b1;
                    uart_addr  = ADDR_POP;
                end
                default: ;
            endcase
        end
    end

    assign rx_valid = r_rx_full;
    assign rx_data  = r_rx_hold;
    assign busy     = (r_state != ST_IDLE) || r_cfg_pending;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cfg_pending <= 1'b0;
            r_cfg_dvsr    <= 11'd0;
            r_rx_full     <= 1'b0;
            r_rx_hold     <= 8'd0;
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_tx_byte     <= 8'd0;
        end else begin
            // A new load arriving in the CFG cycle stays pending for another write.
            if (cfg_load) begin
                r_cfg_pending <= 1'b1;
                r_cfg_dvsr    <= cfg_dvsr;
            end else if (r_state == ST_CFG) begin
                r_cfg_pending <= 1'b0;
            end

            if (w_next_state == ST_POP) begin
                r_rx_hold <= uart_rd_data[7:0];
                r_rx_full <= 1'b1;
            end else if (r_rx_full && rx_ready) begin
                r_rx_full <= 1'b0;
            end

            if (w_next_state == ST_TX) begin
                r_grant   <= w_grant;
                r_tx_byte <= w_grant ? req1_data : req0_data;
            end

            if (r_state == ST_TX) begin
                r_last_grant <= r_grant;
            end
        end
    end

endmodule

// File: tb/tb_uart_slot_arbiter.sv
// Self-checking bench for uart_slot_arbiter: a slot-schedule model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_uart_slot_arbiter;

    localparam logic [10:0] DVSR = 11'd650;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_load;
    logic [10:0] cfg_dvsr;
    logic        req0_valid;
    logic [7:0]  req0_data;
    logic        req0_ready;
    logic        req1_valid;
    logic [7:0]  req1_data;
    logic        req1_ready;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        uart_cs;
    logic        uart_read;
    logic        uart_write;
    logic [4:0]  uart_addr;
    logic [31:0] uart_wr_data;
    logic [31:0] uart_rd_data;
    logic        busy;

    always #5 clk = ~clk;

    uart_slot_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_load     (cfg_load),
        .cfg_dvsr     (cfg_dvsr),
        .req0_valid   (req0_valid),
        .req0_data    (req0_data),
        .req0_ready   (req0_ready),
        .req1_valid   (req1_valid),
        .req1_data    (req1_data),
        .req1_ready   (req1_ready),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_ready     (rx_ready),
        .uart_cs      (uart_cs),
        .uart_read    (uart_read),
        .uart_write   (uart_write),
        .uart_addr    (uart_addr),
        .uart_wr_data (uart_wr_data),
        .uart_rd_data (uart_rd_data),
        .busy         (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Model: each cycle is either a status read (OP_NONE) or the one slot write
    // that the previous status read scheduled.
    typedef enum {OP_NONE, OP_INIT, OP_CFG, OP_TX, OP_POP} op_e;

    typedef struct {
        op_e         op;
        bit          cfg_pend;
        logic [10:0] cfg_val;
        bit          rx_full;
        logic [7:0]  rx_hold;
        bit          last;
        bit          gnt;
        logic [7:0]  tx_byte;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.op = OP_INIT; r.cfg_pend = 0; r.cfg_val = '0; r.rx_full = 0;
        r.rx_hold = '0; r.last = 1; r.gnt = 0; r.tx_byte = '0;
        return r;
    endfunction

    function automatic model_t model_step(input model_t s);
        model_t n = s;
        op_e pick = OP_NONE;
        if (s.op == OP_NONE) begin
            if (s.cfg_pend) pick = OP_CFG;
            else if (!uart_rd_data[8] && !s.rx_full) pick = OP_POP;
            else if (!uart_rd_data[9] && (req0_valid || req1_valid)) pick = OP_TX;
        end
        if (s.op == OP_CFG) n.cfg_pend = 0;
        if (s.op == OP_TX) n.last = s.gnt;
        if (cfg_load) begin
            n.cfg_pend = 1;
            n.cfg_val  = cfg_dvsr;
        end
        if (s.rx_full && rx_ready) n.rx_full = 0;
        if (pick == OP_POP) begin
            n.rx_full = 1;
            n.rx_hold = uart_rd_data[7:0];
        end
        if (pick == OP_TX) begin
            if (req0_valid && req1_valid) n.gnt = !s.last;
            else n.gnt = req1_valid;
            n.tx_byte = n.gnt ? req1_data : req0_data;
        end
        n.op = pick;
        return n;
    endfunction

    // {cs, read, write, addr, wr_data}
    function automatic logic [39:0] exp_bus(input model_t s);
        case (s.op)
            OP_NONE: return {3'b110, 5'd0, 32'd0};
            OP_INIT: return {3'b101, 5'd1, 21'd0, DVSR};
            OP_CFG:  return {3'b101, 5'd1, 21'd0, s.cfg_val};
            OP_TX:   return {3'b101, 5'd2, 24'd0, s.tx_byte};
            default: return {3'b101, 5'd3, 32'd0};
        endcase
    endfunction

    // {req0_ready, req1_ready, rx_valid, rx_data, busy}
    function automatic logic [11:0] exp_side(input model_t s);
        logic is_tx = (s.op == OP_TX);
        return {is_tx && !s.gnt, is_tx && s.gnt, s.rx_full, s.rx_hold,
                (s.op != OP_NONE) || s.cfg_pend};
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= model_reset();
        else m <= model_step(m);
    end

    always @(negedge clk) begin
        check("bus", {uart_cs, uart_read, uart_write, uart_addr, uart_wr_data},
              reset ? 40'd0 : exp_bus(m));
        check("side", {req0_ready, req1_ready, rx_valid, rx_data, busy},
              reset ? 12'b0000_0000_0001 : exp_side(m));
    end

    // Transaction monitor feeding the directed scenarios.
    int          cyc = 0;
    logic [7:0]  tx_log[$];
    bit          tx_who[$];
    int          tx_cyc[$];
    logic [1:0]  op_log[$];
    logic [10:0] cfg_log[$];
    int          pop_cnt = 0;
    int          ready_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset) begin
            if (req0_ready || req1_ready) ready_seen <= ready_seen + 1;
            if (uart_write) begin
                op_log.push_back(uart_addr[1:0]);
                if (uart_addr == 5'd2) begin
                    tx_log.push_back(uart_wr_data[7:0]);
                    tx_who.push_back(req1_ready);
                    tx_cyc.push_back(cyc);
                end
                if (uart_addr == 5'd1) cfg_log.push_back(uart_wr_data[10:0]);
                if (uart_addr == 5'd3) pop_cnt <= pop_cnt + 1;
            end
        end
    end

    function automatic logic [31:0] st(input bit tx_full, input bit rx_empty, input logic [7:0] b);
        return {22'd0, tx_full, rx_empty, b};
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  base_tx, base_rdy, base_pop, base_op, base_cfg, waited;
        bit  found;
        cfg_load = 0; cfg_dvsr = '0; rx_ready = 0;
        req0_valid = 0; req0_data = '0; req1_valid = 0; req1_data = '0;
        uart_rd_data = st(0, 1, 8'h00);

        // Reset values and the INIT divisor write.
        repeat (2) @(negedge clk);
        check("rst_bus", {uart_cs, uart_read, uart_write, uart_addr, uart_wr_data}, 40'd0);
        check("rst_busy_rx", {busy, rx_valid, rx_data}, {1'b1, 1'b0, 8'h00});
        tick();
        reset = 0;
        @(negedge clk);
        check("init_write", {uart_cs, uart_write, uart_read, uart_addr, uart_wr_data},
              {1'b1, 1'b1, 1'b0, 5'd1, 32'd650});
        @(negedge clk);
        check("idle_read", {uart_cs, uart_read, uart_write, uart_addr, busy},
              {1'b1, 1'b1, 1'b0, 5'd0, 1'b0});

        // Round-robin between two continuously valid requesters.
        tick();
        base_tx = tx_log.size();
        req0_valid = 1; req0_data = 8'h41; req1_valid = 1; req1_data = 8'h42;
        tick(12);
        req0_valid = 0; req1_valid = 0;
        check("rr_count", (tx_log.size() - base_tx >= 4), 1);
        if (tx_log.size() - base_tx >= 4) begin
            check("rr_bytes", {tx_log[base_tx], tx_log[base_tx+1], tx_log[base_tx+2], tx_log[base_tx+3]},
                  32'h41424142);
            check("rr_ready", {tx_who[base_tx], tx_who[base_tx+1], tx_who[base_tx+2], tx_who[base_tx+3]},
                  4'b0101);
            check("rr_spacing", tx_cyc[base_tx+2] - tx_cyc[base_tx+1], 2);
        end
        tick(2);

        // tx_full stalls requester 0 until it drops.
        uart_rd_data = st(1, 1, 8'h00);
        base_tx = tx_log.size(); base_rdy = ready_seen;
        req0_valid = 1; req0_data = 8'h33;
        tick(6);
        check("stall_no_tx", tx_log.size() - base_tx, 0);
        check("stall_no_ready", ready_seen - base_rdy, 0);
        uart_rd_data = st(0, 1, 8'h00);
        found = 0; waited = 0;
        for (int i = 1; i <= 4 && !found; i++) begin
            @(negedge clk);
            if (req0_ready && uart_write && uart_addr == 5'd2) begin
                found = 1; waited = i;
            end
        end
        check("unstall_tx", {found, uart_wr_data[7:0]}, {1'b1, 8'h33});
        check("unstall_latency", waited, 2);
        tick();
        req0_valid = 0;
        tick(2);

        // One POP into the holding register, none again until it is consumed.
        base_pop = pop_cnt;
        uart_rd_data = st(1, 0, 8'h5A);
        tick(6);
        check("pop_once", pop_cnt - base_pop, 1);
        check("rx_hold_5a", {rx_valid, rx_data}, {1'b1, 8'h5A});
        rx_ready = 1; uart_rd_data = st(1, 0, 8'hA5);
        tick();
        rx_ready = 0;
        tick(4);
        check("pop_after_ready", pop_cnt - base_pop, 2);
        check("rx_hold_a5", {rx_valid, rx_data}, {1'b1, 8'hA5});
        uart_rd_data = st(1, 1, 8'h00); rx_ready = 1;
        tick();
        rx_ready = 0;
        tick();
        check("rx_drained", rx_valid, 0);

        // Two cfg_loads collapse into one CFG write served ahead of POP and TX.
        uart_rd_data = st(0, 1, 8'h00);
        req0_valid = 1; req0_data = 8'h41; req1_valid = 1; req1_data = 8'h42;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            found = uart_write && uart_addr == 5'd2;
        end
        check("cfg_sync_tx", found, 1);
        tick();
        base_op = op_log.size(); base_cfg = cfg_log.size();
        cfg_load = 1; cfg_dvsr = 11'h100;
        tick();
        cfg_dvsr = 11'h1A0; uart_rd_data = st(0, 0, 8'h77);
        tick();
        cfg_load = 0;
        tick(6);
        req0_valid = 0; req1_valid = 0;
        check("cfg_single", cfg_log.size() - base_cfg, 1);
        if (cfg_log.size() > base_cfg) check("cfg_value", cfg_log[base_cfg], 11'h1A0);
        check("cfg_order_len", (op_log.size() - base_op >= 3), 1);
        if (op_log.size() - base_op >= 3)
            check("cfg_order", {op_log[base_op], op_log[base_op+1], op_log[base_op+2]}, 6'b10_01_11);
        tick();
        uart_rd_data = st(0, 1, 8'h00);
        check("rx_full_pre_reset", {rx_valid, rx_data}, {1'b1, 8'h77});

        // Reset in the middle of a TX cycle drops the byte.
        req0_valid = 1; req0_data = 8'hC3;
        found = 0;
        for (int i = 0; i < 6 && !found; i++) begin
            @(negedge clk);
            found = uart_write && uart_addr == 5'd2;
        end
        check("rst_sync_tx", found, 1);
        #1;
        reset = 1; req0_valid = 0;
        base_tx = tx_log.size();
        tick();
        check("rst_mid_bus", {uart_cs, uart_read, uart_write, uart_addr, uart_wr_data, req0_ready}, 41'd0);
        check("rst_mid_side", {busy, rx_valid, rx_data}, {1'b1, 1'b0, 8'h00});
        reset = 0;
        @(negedge clk);
        check("rst_init_write", {uart_write, uart_addr, uart_wr_data, rx_valid},
              {1'b1, 5'd1, 32'd650, 1'b0});
        tick(6);
        check("rst_no_replay", tx_log.size() - base_tx, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
